// File: rtl/hex_display_scan.sv
// Multiplexed scanner for a common-anode 7-segment display.
// The display word is double-buffered, so it only changes at frame boundaries.
module hex_display_scan #(
    parameter int DIGITS = 8,
    parameter int DIV    = 100000,
    parameter int BLANK  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic                  load_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     digit_en_i,
    output logic [3:0]            x_o,
    output logic                  dp_n_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_act_data;
    logic [DIGITS-1:0]     r_act_dp;
    logic [4*DIGITS-1:0]   r_pend_data;
    logic [DIGITS-1:0]     r_pend_dp;
    logic                  r_pend_valid;
    logic [3:0]            r_x;
    logic                  r_dp_n;
    logic [DIGITS-1:0]     r_an;
    logic                  r_frame;

    logic                  w_slot_end;
    logic                  w_frame_end;
    logic                  w_swap;
    logic [CW-1:0]         w_cnt_nxt;
    logic [IW-1:0]         w_idx_nxt;
    logic [4*DIGITS-1:0]   w_act_data_nxt;
    logic [DIGITS-1:0]     w_act_dp_nxt;
    state_t                w_state_nxt;

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
    assign w_swap      = w_frame_end && r_pend_valid;

    assign w_cnt_nxt = w_slot_end ? '0 : r_cnt + CW'(1);
    assign w_idx_nxt = w_frame_end ? '0 :
                       w_slot_end  ? r_idx + IW'(1) : r_idx;

    // Swap uses the pending value from before this edge, so a load on the
    // frame-end cycle waits a full frame instead of tearing the current one.
    assign w_act_data_nxt = w_swap ? r_pend_data : r_act_data;
    assign w_act_dp_nxt   = w_swap ? r_pend_dp   : r_act_dp;

    assign w_state_nxt = (w_cnt_nxt < CNT_BLANK) ? ST_BLANK : ST_SHOW;

    // Outputs are registered from next-state values so they line up with cnt/idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_x          <= '0;
            r_dp_n       <= 1'b1;
            r_an         <= '1;
            r_frame      <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_act_data <= w_act_data_nxt;
            r_act_dp   <= w_act_dp_nxt;
            if (load_i) begin
                r_pend_data  <= data_i;
                r_pend_dp    <= dp_i;
                r_pend_valid <= 1'b1;
            end else if (w_swap) begin
                r_pend_valid <= 1'b0;
            end
            r_x     <= w_act_data_nxt[{w_idx_nxt, 2'b00} +: 4];
            r_frame <= (w_cnt_nxt == CNT_LAST) && (w_idx_nxt == IDX_LAST);
            r_an    <= '1;
            r_dp_n  <= 1'b1;
            unique case (w_state_nxt)
                ST_BLANK: begin
                end
                ST_SHOW: begin
                    r_an[w_idx_nxt] <= ~digit_en_i[w_idx_nxt];
                    r_dp_n <= ~(w_act_dp_nxt[w_idx_nxt]
                              & digit_en_i[w_idx_nxt]);
                end
                default: begin
                end
            endcase
        end
    end

    assign x_o     = r_x;
    assign dp_n_o  = r_dp_n;
    assign an_o    = r_an;
    assign frame_o = r_frame;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with DIGITS=4, DIV=10, BLANK=2.
// Cycle 0 is the first cycle after reset is released; one frame is 40 cycles.
module tb_hex_display_scan;

    localparam int DIGITS = 4;
    localparam int DIV    = 10;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_i = '0;
    logic        load_i = 1'b0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  digit_en_i = 4'hF;
    logic [3:0]  x_o;
    logic        dp_n_o;
    logic [3:0]  an_o;
    logic        frame_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hex_display_scan #(
        .DIGITS(DIGITS),
        .DIV(DIV),
        .BLANK(BLANK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_i(data_i),
        .load_i(load_i),
        .dp_i(dp_i),
        .digit_en_i(digit_en_i),
        .x_o(x_o),
        .dp_n_o(dp_n_o),
        .an_o(an_o),
        .frame_o(frame_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] e_x(input logic [15:0] w, input int c);
        logic [15:0] t;
        t = w >> (4 * (c / DIV));
        return t[3:0];
    endfunction

    function automatic logic [3:0] e_an(input int c, input logic [3:0] en);
        logic [3:0] m;
        logic [1:0] s;
        m = 4'hF;
        s = 2'(c / DIV);
        if ((c % DIV) >= BLANK && en[s]) m[s] = 1'b0;
        return m;
    endfunction

    function automatic logic e_dpn(input int c, input logic [3:0] dp,
                                   input logic [3:0] en);
        logic [1:0] s;
        s = 2'(c / DIV);
        if ((c % DIV) < BLANK) return 1'b1;
        return !(dp[s] && en[s]);
    endfunction

    function automatic logic e_frm(input int c);
        return c == FRAME - 1;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        load_i = 1'b1;
        data_i = 16'hFFFF;
        dp_i = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests += 4;
            if (an_o !== 4'hF) begin
                fails++;
                $display("FAIL reset_an i=%0d got %h exp f", i, an_o);
            end
            if (x_o !== 4'h0) begin
                fails++;
                $display("FAIL reset_x i=%0d got %h exp 0", i, x_o);
            end
            if (dp_n_o !== 1'b1) begin
                fails++;
                $display("FAIL reset_dpn i=%0d got %b exp 1", i, dp_n_o);
            end
            if (frame_o !== 1'b0) begin
                fails++;
                $display("FAIL reset_frame i=%0d got %b exp 0", i, frame_o);
            end
        end
        rst = 1'b0;
        load_i = 1'b0;
        data_i = '0;
        dp_i = '0;
    endtask

    // Frame 0 must show zeros; 1234 loaded at cycle 0 appears in frame 1.
    task automatic test_basic;
        logic [15:0] w;
        logic [3:0]  d;
        for (int f = 0; f < 2; f++) begin
            w = (f == 0) ? 16'h0000 : 16'h1234;
            d = (f == 0) ? 4'b0000 : 4'b0010;
            for (int c = 0; c < FRAME; c++) begin
                tests += 4;
                if (x_o !== e_x(w, c)) begin
                    fails++;
                    $display("FAIL basic_x f=%0d c=%0d got %h exp %h",
                             f, c, x_o, e_x(w, c));
                end
                if (an_o !== e_an(c, 4'hF)) begin
                    fails++;
                    $display("FAIL basic_an f=%0d c=%0d got %b exp %b",
                             f, c, an_o, e_an(c, 4'hF));
                end
                if (dp_n_o !== e_dpn(c, d, 4'hF)) begin
                    fails++;
                    $display("FAIL basic_dpn f=%0d c=%0d got %b exp %b",
                             f, c, dp_n_o, e_dpn(c, d, 4'hF));
                end
                if (frame_o !== e_frm(c)) begin
                    fails++;
                    $display("FAIL basic_frame f=%0d c=%0d got %b exp %b",
                             f, c, frame_o, e_frm(c));
                end
                load_i = (f == 0 && c == 0);
                if (load_i) begin
                    data_i = 16'h1234;
                    dp_i = 4'b0010;
                end
                tick();
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_tear_free;
        logic [15:0] w;
        logic [3:0]  d;
        for (int f = 0; f < 2; f++) begin
            w = (f == 0) ? 16'h1234 : 16'hABCD;
            d = (f == 0) ? 4'b0010 : 4'b0000;
            for (int c = 0; c < FRAME; c++) begin
                tests += 3;
                if (x_o !== e_x(w, c)) begin
                    fails++;
                    $display("FAIL tear_x f=%0d c=%0d got %h exp %h",
                             f, c, x_o, e_x(w, c));
                end
                if (dp_n_o !== e_dpn(c, d, 4'hF)) begin
                    fails++;
                    $display("FAIL tear_dpn f=%0d c=%0d got %b exp %b",
                             f, c, dp_n_o, e_dpn(c, d, 4'hF));
                end
                if (frame_o !== e_frm(c)) begin
                    fails++;
                    $display("FAIL tear_frame f=%0d c=%0d got %b exp %b",
                             f, c, frame_o, e_frm(c));
                end
                load_i = (f == 0 && c == 15);
                if (load_i) begin
                    data_i = 16'hABCD;
                    dp_i = 4'b0000;
                end
                tick();
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_last_wins;
        logic [15:0] w;
        for (int f = 0; f < 2; f++) begin
            w = (f == 0) ? 16'hABCD : 16'h2222;
            for (int c = 0; c < FRAME; c++) begin
                tests += 2;
                if (x_o !== e_x(w, c)) begin
                    fails++;
                    $display("FAIL last_x f=%0d c=%0d got %h exp %h",
                             f, c, x_o, e_x(w, c));
                end
                if (an_o !== e_an(c, 4'hF)) begin
                    fails++;
                    $display("FAIL last_an f=%0d c=%0d got %b exp %b",
                             f, c, an_o, e_an(c, 4'hF));
                end
                load_i = (f == 0 && (c == 5 || c == 30));
                if (f == 0 && c == 5) data_i = 16'h1111;
                if (f == 0 && c == 30) data_i = 16'h2222;
                tick();
            end
        end
        load_i = 1'b0;
    endtask

    // A load on the frame-end cycle must skip that frame end.
    task automatic test_back_to_back;
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                tests += 2;
                if (x_o !== e_x(16'h2222, c)) begin
                    fails++;
                    $display("FAIL b2b_x f=%0d c=%0d got %h exp %h",
                             f, c, x_o, e_x(16'h2222, c));
                end
                if (dp_n_o !== e_dpn(c, 4'b0000, 4'hF)) begin
                    fails++;
                    $display("FAIL b2b_dpn f=%0d c=%0d got %b exp %b",
                             f, c, dp_n_o, e_dpn(c, 4'b0000, 4'hF));
                end
                load_i = (f == 0 && c == FRAME - 1);
                if (load_i) begin
                    data_i = 16'h5678;
                    dp_i = 4'hF;
                end
                tick();
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_digit_en;
        logic [3:0] en_q;
        digit_en_i = 4'b0101;
        en_q = digit_en_i;
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                tests += 3;
                if (x_o !== e_x(16'h5678, c)) begin
                    fails++;
                    $display("FAIL en_x f=%0d c=%0d got %h exp %h",
                             f, c, x_o, e_x(16'h5678, c));
                end
                if (an_o !== e_an(c, en_q)) begin
                    fails++;
                    $display("FAIL en_an f=%0d c=%0d got %b exp %b",
                             f, c, an_o, e_an(c, en_q));
                end
                if (dp_n_o !== e_dpn(c, 4'hF, en_q)) begin
                    fails++;
                    $display("FAIL en_dpn f=%0d c=%0d got %b exp %b",
                             f, c, dp_n_o, e_dpn(c, 4'hF, en_q));
                end
                if (f == 1) digit_en_i = (c == 5) ? 4'h0 : 4'hF;
                en_q = digit_en_i;
                tick();
            end
        end
    endtask

    task automatic test_mid_reset;
        for (int c = 0; c < 26; c++) begin
            tests += 2;
            if (x_o !== e_x(16'h5678, c)) begin
                fails++;
                $display("FAIL mrst_x c=%0d got %h exp %h",
                         c, x_o, e_x(16'h5678, c));
            end
            if (an_o !== e_an(c, 4'hF)) begin
                fails++;
                $display("FAIL mrst_an c=%0d got %b exp %b",
                         c, an_o, e_an(c, 4'hF));
            end
            load_i = (c == 3);
            if (load_i) data_i = 16'h9999;
            rst = (c == 25);
            tick();
        end
        tests += 4;
        if (an_o !== 4'hF) begin
            fails++;
            $display("FAIL mrst_an_now got %b exp 1111", an_o);
        end
        if (x_o !== 4'h0) begin
            fails++;
            $display("FAIL mrst_x_now got %h exp 0", x_o);
        end
        if (dp_n_o !== 1'b1) begin
            fails++;
            $display("FAIL mrst_dpn_now got %b exp 1", dp_n_o);
        end
        if (frame_o !== 1'b0) begin
            fails++;
            $display("FAIL mrst_frame_now got %b exp 0", frame_o);
        end
        rst = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                tests += 4;
                if (x_o !== 4'h0) begin
                    fails++;
                    $display("FAIL mrst_after_x f=%0d c=%0d got %h exp 0",
                             f, c, x_o);
                end
                if (an_o !== e_an(c, 4'hF)) begin
                    fails++;
                    $display("FAIL mrst_after_an f=%0d c=%0d got %b exp %b",
                             f, c, an_o, e_an(c, 4'hF));
                end
                if (dp_n_o !== e_dpn(c, 4'b0000, 4'hF)) begin
                    fails++;
                    $display("FAIL mrst_after_dpn f=%0d c=%0d got %b exp %b",
                             f, c, dp_n_o, e_dpn(c, 4'b0000, 4'hF));
                end
                if (frame_o !== e_frm(c)) begin
                    fails++;
                    $display("FAIL mrst_after_frame f=%0d c=%0d got %b exp %b",
                             f, c, frame_o, e_frm(c));
                end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tear_free();
        test_last_wins();
        test_back_to_back();
        test_digit_en();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
